ps2_receiver: RTL and testbench

//  Host-side PS/2 receiver for the USB-HID PS/2 pins of the Basys3 board.

---
 rtl/ps2_receiver.sv | 145 ++++++++++++++
 tb/tb_ps2_receiver.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ps2_receiver.sv
// Host-side PS/2 receiver: filters the device clock, deserialises 11-bit frames
// and presents each byte on a valid/ready port. Never drives the PS/2 pins.
//
// state  | meaning
// IDLE   | waiting for a start bit (data low on a filtered falling edge)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | checking stop bit and parity, delivering or discarding the byte
module ps2_receiver #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt_clk;
  logic [FW-1:0] filt_cnt;
  logic [TW-1:0] to_cnt;
  logic [1:0]    state;
  logic [7:0]    shreg;
  logic [2:0]    bit_cnt;
  logic          par_bit;
  logic          fall, timeout, par_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // Filtered level flips on the FILTER_LEN-th consecutive differing sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s2 == filt_clk) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FILT_LAST) begin
      filt_clk <= clk_s2;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FW'(1);
    end
  end

  assign fall    = filt_clk && !clk_s2 && (filt_cnt == FILT_LAST);
  assign timeout = (state != IDLE) && !fall && (to_cnt == TO_LAST);
  assign par_ok  = ^{shreg, par_bit};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state == IDLE || fall) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= 8'h00;
      bit_cnt    <= 3'd0;
      par_bit    <= 1'b0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (timeout) begin
        state     <= IDLE;
        frame_err <= 1'b1;
      end else if (fall) begin
        case (state)
          IDLE: begin
            if (!dat_s2) begin
              state   <= DATA;
              bit_cnt <= 3'd0;
            end
          end
          DATA: begin
            shreg   <= {dat_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_bit <= dat_s2;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (par_ok && dat_s2) begin
              // Accept in the same cycle frees the register for the new byte
              if (!rx_valid || rx_ready) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              parity_err <= !par_ok;
              frame_err  <= !dat_s2;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_receiver.sv
// Self-checking bench for ps2_receiver: byte scoreboard on the handshake,
// error pulses counted in cycles and compared per scenario.
module tb_ps2_receiver;

  localparam int HALF = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       parity_err, frame_err, overrun;

  int n_checks = 0;
  int n_errors = 0;
  int pe_cyc = 0, fe_cyc = 0, ov_cyc = 0;
  int pe0, fe0, ov0;
  logic [7:0] exp_q[$];

  ps2_receiver #(.FILTER_LEN(4), .TIMEOUT_CYCLES(2000)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard pops on every accepted byte; pulse widths accumulate as cycle counts
  always @(negedge clk) begin
    if (parity_err) pe_cyc++;
    if (frame_err)  fe_cyc++;
    if (overrun)    ov_cyc++;
    if (!rst && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) check("unexpected_byte", {24'h0, rx_data}, 32'h0);
      else check("rx_data_accept", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input int nbits);
    logic [10:0] bits;
    bits = {stp, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_cyc(20);
  endtask

  task automatic snap();
    pe0 = pe_cyc; fe0 = fe_cyc; ov0 = ov_cyc;
  endtask

  task automatic accept();
    rx_ready = 1'b1;
    wait_cyc(1);
    rx_ready = 1'b0;
    wait_cyc(1);
  endtask

  initial begin
    wait_cyc(3);
    check("reset_rx_valid", {31'h0, rx_valid}, 32'h0);
    check("reset_rx_data", {24'h0, rx_data}, 32'h0);
    check("reset_errs", {29'h0, parity_err, frame_err, overrun}, 32'h0);
    rst = 1'b0;
    wait_cyc(5);

    // good 0x1C, then a one-cycle accept
    snap();
    exp_q.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    check("good_valid", {31'h0, rx_valid}, 32'h1);
    check("good_data", {24'h0, rx_data}, 32'h1C);
    check("good_no_err", pe_cyc + fe_cyc + ov_cyc - pe0 - fe0 - ov0, 0);
    rx_ready = 1'b1;
    wait_cyc(1);
    rx_ready = 1'b0;
    check("accept_clears", {31'h0, rx_valid}, 32'h0);

    // bad parity
    snap();
    send_frame(8'h1C, 1'b1, 1'b1, 11);
    check("par_err_pulse", pe_cyc - pe0, 1);
    check("par_no_fe", fe_cyc - fe0, 0);
    check("par_no_valid", {31'h0, rx_valid}, 32'h0);

    // stop bit 0
    snap();
    send_frame(8'h5A, 1'b1, 1'b0, 11);
    check("stop_fe_pulse", fe_cyc - fe0, 1);
    check("stop_no_pe", pe_cyc - pe0, 0);
    check("stop_no_valid", {31'h0, rx_valid}, 32'h0);

    // overrun
    snap();
    exp_q.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    send_frame(8'hF0, 1'b1, 1'b1, 11);
    check("ovr_pulse", ov_cyc - ov0, 1);
    check("ovr_data_kept", {24'h0, rx_data}, 32'h1C);
    check("ovr_valid", {31'h0, rx_valid}, 32'h1);
    accept();
    check("ovr_drained", {31'h0, rx_valid}, 32'h0);

    // timeout on a partial frame, then recovery
    snap();
    send_frame(8'h05, 1'b0, 1'b1, 4);
    check("to_not_yet", fe_cyc - fe0, 0);
    wait_cyc(2100);
    check("to_fe_pulse", fe_cyc - fe0, 1);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b1, 11);
    check("to_recover_data", {24'h0, rx_data}, 32'h5A);
    accept();

    // 2-cycle glitch in IDLE
    snap();
    ps2_clk = 1'b0;
    wait_cyc(2);
    ps2_clk = 1'b1;
    wait_cyc(30);
    check("glitch_no_err", pe_cyc + fe_cyc + ov_cyc - pe0 - fe0 - ov0, 0);
    check("glitch_no_valid", {31'h0, rx_valid}, 32'h0);
    exp_q.push_back(8'h33);
    send_frame(8'h33, 1'b1, 1'b1, 11);
    check("glitch_next_data", {24'h0, rx_data}, 32'h33);

    // async reset mid-DATA with a byte still pending
    send_frame(8'hA5, 1'b1, 1'b1, 5);
    rst = 1'b1;
    #1;
    check("rst_valid", {31'h0, rx_valid}, 32'h0);
    check("rst_data", {24'h0, rx_data}, 32'h0);
    exp_q.delete();
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(5);
    exp_q.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    check("rst_next_data", {24'h0, rx_data}, 32'h1C);
    accept();
    check("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
